cpu_run_controller: RTL and testbench

Execution sequencer for the single-cycle computer on the DE2 board. Replaces the free-running clock mux with a single clock domain: the computer runs on `clock` and advances only when `cpu_enable` pulses. The block generates those pulses from a manual step button (single-step mode) or a periodic tick (run mode). It also halts on a PC breakpoint or a halt instruction, and keeps the executed-cycle count shown on HEX3..HEX0.

---
 rtl/cpu_run_controller.sv | 132 +++++++++++++
 tb/tb_cpu_run_controller.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Execution sequencer for the single-cycle computer. The computer runs on `clock` and
// advances only when `cpu_enable` pulses. Pulses come from a synchronized step button
// (single-step mode) or from `run_tick` (run mode). Execution halts on a PC breakpoint
// or on a halt instruction, and the number of issued pulses is kept in `cycle_count`.
//
// Ports:
//   clock          in   system clock, all state on rising edge
//   reset          in   asynchronous active-high reset, forces INIT
//   step_button    in   debounced step button level (asynchronous)
//   run_tick       in   one-clock strobe, synchronous
//   mode           in   0 = single-step, 1 = run (asynchronous level)
//   bp_enable      in   breakpoint enable
//   bp_address     in   [31:0] breakpoint PC
//   pc             in   [31:0] current PC of the computer
//   instruction    in   [31:0] instruction at pc
//   cpu_enable     out  one-cycle advance strobe
//   register_reset out  register-file clear request (reset and INIT only)
//   cycle_count    out  [15:0] number of cpu_enable pulses, wraps at 2^16
//   halted         out  high while in HALT
//   state          out  [1:0] INIT=00, STEP=01, RUN=10, HALT=11
module cpu_run_controller #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_button,
    input  logic        run_tick,
    input  logic        mode,
    input  logic        bp_enable,
    input  logic [31:0] bp_address,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        cpu_enable,
    output logic        register_reset,
    output logic [15:0] cycle_count,
    output logic        halted,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StInit = 2'b00,
        StStep = 2'b01,
        StRun  = 2'b10,
        StHalt = 2'b11
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic        w_pulse;
    logic        r_step_s1;
    logic        r_step_s2;
    logic        r_step_s3;
    logic        r_mode_s1;
    logic        r_mode_s2;
    logic        r_cpu_enable;
    logic        r_register_reset;
    logic [15:0] r_cycle_count;
    logic        r_halted;
    logic        w_step_edge;
    logic        w_halt_cond;

    assign w_step_edge = r_step_s2 & ~r_step_s3;
    assign w_halt_cond = (bp_enable && (pc == bp_address)) || (instruction == HALT_WORD);

    // A request in a cycle always takes priority over a pending mode change, which is
    // then picked up on the following cycle since synced mode is still stable.
    always_comb begin
        w_state_d = r_state;
        w_pulse   = 1'b0;
        case (r_state)
            StInit: w_state_d = StStep;
            StStep: begin
                if (w_step_edge) begin
                    if (w_halt_cond) w_state_d = StHalt;
                    else             w_pulse   = 1'b1;
                end else if (r_mode_s2) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (run_tick) begin
                    if (w_halt_cond) w_state_d = StHalt;
                    else             w_pulse   = 1'b1;
                end else if (!r_mode_s2) begin
                    w_state_d = StStep;
                end
            end
            StHalt: begin
                // Resume bypasses the halt check once, otherwise the same PC would re-halt.
                if (w_step_edge) begin
                    w_pulse   = 1'b1;
                    w_state_d = r_mode_s2 ? StRun : StStep;
                end
            end
            default: w_state_d = StInit;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state          <= StInit;
            r_step_s1        <= 1'b0;
            r_step_s2        <= 1'b0;
            r_step_s3        <= 1'b0;
            r_mode_s1        <= 1'b0;
            r_mode_s2        <= 1'b0;
            r_cpu_enable     <= 1'b0;
            r_register_reset <= 1'b1;
            r_cycle_count    <= 16'd0;
            r_halted         <= 1'b0;
        end else begin
            r_state          <= w_state_d;
            r_step_s1        <= step_button;
            r_step_s2        <= r_step_s1;
            r_step_s3        <= r_step_s2;
            r_mode_s1        <= mode;
            r_mode_s2        <= r_mode_s1;
            r_cpu_enable     <= w_pulse;
            r_register_reset <= (w_state_d == StInit);
            r_cycle_count    <= r_cycle_count + {15'd0, w_pulse};
            r_halted         <= (w_state_d == StHalt);
        end
    end

    assign cpu_enable     = r_cpu_enable;
    assign register_reset = r_register_reset;
    assign cycle_count    = r_cycle_count;
    assign halted         = r_halted;
    assign state          = r_state;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: a per-cycle vector table for the
// step/run/mode basics, followed by hand-written sequences for run ticks, breakpoint,
// halt instruction, counter wrap and reset during a pulse.
module tb_cpu_run_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        step_button;
    logic        run_tick;
    logic        mode;
    logic        bp_enable;
    logic [31:0] bp_address;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        cpu_enable;
    logic        register_reset;
    logic [15:0] cycle_count;
    logic        halted;
    logic [1:0]  state;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic        sb;
        logic        tk;
        logic        md;
        logic        ce;
        logic [1:0]  st;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    cpu_run_controller dut (
        .clock          (clock),
        .reset          (reset),
        .step_button    (step_button),
        .run_tick       (run_tick),
        .mode           (mode),
        .bp_enable      (bp_enable),
        .bp_address     (bp_address),
        .pc             (pc),
        .instruction    (instruction),
        .cpu_enable     (cpu_enable),
        .register_reset (register_reset),
        .cycle_count    (cycle_count),
        .halted         (halted),
        .state          (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic sb, input logic tk, input logic md, input logic ce,
                           input logic [1:0] st, input logic [15:0] cnt);
        vec_t v;
        v.sb = sb; v.tk = tk; v.md = md; v.ce = ce; v.st = st; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Leaves reset released at a falling edge; the next rising edge moves INIT -> STEP.
    task automatic do_reset();
        reset       = 1'b1;
        step_button = 1'b0;
        run_tick    = 1'b0;
        mode        = 1'b0;
        bp_enable   = 1'b0;
        bp_address  = 32'd0;
        pc          = 32'd0;
        instruction = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic tick_edge();
        @(posedge clock);
        #1;
    endtask

    int errs;
    int pulses;

    initial begin
        // STEP mode, step presses, mode switching, simultaneous request/mode change
        add_vec(0, 0, 0, 0, 2'b01, 16'd0);
        add_vec(1, 0, 0, 0, 2'b01, 16'd0);
        add_vec(1, 0, 0, 0, 2'b01, 16'd0);
        add_vec(1, 0, 0, 1, 2'b01, 16'd1);
        add_vec(1, 0, 0, 0, 2'b01, 16'd1);
        add_vec(0, 0, 0, 0, 2'b01, 16'd1);
        add_vec(0, 0, 0, 0, 2'b01, 16'd1);
        add_vec(1, 0, 0, 0, 2'b01, 16'd1);
        add_vec(1, 0, 0, 0, 2'b01, 16'd1);
        add_vec(1, 0, 0, 1, 2'b01, 16'd2);
        add_vec(0, 0, 0, 0, 2'b01, 16'd2);
        add_vec(0, 0, 1, 0, 2'b01, 16'd2);
        add_vec(0, 0, 1, 0, 2'b01, 16'd2);
        add_vec(0, 0, 1, 0, 2'b10, 16'd2);
        add_vec(0, 1, 1, 1, 2'b10, 16'd3);
        add_vec(1, 0, 1, 0, 2'b10, 16'd3);
        add_vec(1, 0, 1, 0, 2'b10, 16'd3);
        add_vec(1, 0, 1, 0, 2'b10, 16'd3);
        add_vec(0, 1, 1, 1, 2'b10, 16'd4);
        add_vec(0, 0, 0, 0, 2'b10, 16'd4);
        add_vec(0, 0, 0, 0, 2'b10, 16'd4);
        add_vec(0, 0, 0, 0, 2'b01, 16'd4);
        add_vec(0, 1, 0, 0, 2'b01, 16'd4);
        add_vec(1, 0, 1, 0, 2'b01, 16'd4);
        add_vec(1, 0, 1, 0, 2'b01, 16'd4);
        add_vec(1, 0, 1, 1, 2'b01, 16'd5);
        add_vec(1, 0, 1, 0, 2'b10, 16'd5);
        add_vec(0, 1, 1, 1, 2'b10, 16'd6);

        // Reset values while reset is held
        reset = 1'b1; step_button = 1'b0; run_tick = 1'b0; mode = 1'b0;
        bp_enable = 1'b0; bp_address = 32'd0; pc = 32'd0; instruction = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst ce", {31'd0, cpu_enable}, 32'd0);
        chk("rst rr", {31'd0, register_reset}, 32'd1);
        chk("rst cnt", {16'd0, cycle_count}, 32'd0);
        chk("rst halted", {31'd0, halted}, 32'd0);
        chk("rst state", {30'd0, state}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step_button = vecs[i].sb;
            run_tick    = vecs[i].tk;
            mode        = vecs[i].md;
            tick_edge();
            chk($sformatf("row%0d ce", i), {31'd0, cpu_enable}, {31'd0, vecs[i].ce});
            chk($sformatf("row%0d state", i), {30'd0, state}, {30'd0, vecs[i].st});
            chk($sformatf("row%0d cnt", i), {16'd0, cycle_count}, {16'd0, vecs[i].cnt});
            chk($sformatf("row%0d halted", i), {31'd0, halted}, 32'd0);
            chk($sformatf("row%0d rr", i), {31'd0, register_reset}, 32'd0);
        end

        // Run mode: 20 ticks, step button toggling throughout must be ignored
        do_reset();
        mode = 1'b1;
        repeat (3) tick_edge();
        chk("run entry state", {30'd0, state}, 32'd2);
        errs = 0;
        for (int c = 0; c < 80; c++) begin
            run_tick    = (c % 4 == 0);
            step_button = c[0];
            tick_edge();
            if (cpu_enable !== (c % 4 == 0)) errs++;
        end
        run_tick = 1'b0; step_button = 1'b0;
        chk("run pulse timing errors", errs, 0);
        chk("run cnt", {16'd0, cycle_count}, 32'd20);
        chk("run state", {30'd0, state}, 32'd2);

        // Breakpoint at 0x10, PC advancing by 4 per pulse
        do_reset();
        mode = 1'b1; bp_enable = 1'b1; bp_address = 32'h10; pc = 32'd0;
        repeat (3) tick_edge();
        pulses = 0;
        errs   = 0;
        for (int t = 0; t < 8; t++) begin
            run_tick = 1'b1;
            tick_edge();
            if (cpu_enable) begin
                pulses++;
                pc = pc + 32'd4;
            end
            run_tick = 1'b0;
            tick_edge();
            if (cpu_enable) errs++;
        end
        chk("bp pulses", pulses, 4);
        chk("bp stray pulses", errs, 0);
        chk("bp pc", pc, 32'h10);
        chk("bp halted", {31'd0, halted}, 32'd1);
        chk("bp state", {30'd0, state}, 32'd3);
        chk("bp cnt", {16'd0, cycle_count}, 32'd4);
        step_button = 1'b1;
        repeat (3) tick_edge();
        chk("resume ce", {31'd0, cpu_enable}, 32'd1);
        chk("resume halted", {31'd0, halted}, 32'd0);
        chk("resume state", {30'd0, state}, 32'd2);
        chk("resume cnt", {16'd0, cycle_count}, 32'd5);
        tick_edge();
        chk("resume one pulse", {31'd0, cpu_enable}, 32'd0);
        step_button = 1'b0;

        // Halt instruction in STEP mode
        do_reset();
        instruction = 32'hFFFF_FFFF;
        tick_edge();
        step_button = 1'b1;
        repeat (3) tick_edge();
        chk("hw ce", {31'd0, cpu_enable}, 32'd0);
        chk("hw state", {30'd0, state}, 32'd3);
        chk("hw halted", {31'd0, halted}, 32'd1);
        chk("hw cnt", {16'd0, cycle_count}, 32'd0);
        step_button = 1'b0;
        instruction = 32'd0;

        // Counter wrap after 65535 pulses
        do_reset();
        mode = 1'b1;
        repeat (3) tick_edge();
        run_tick = 1'b1;
        repeat (65535) tick_edge();
        run_tick = 1'b0;
        chk("wrap preload", {16'd0, cycle_count}, 32'hFFFF);
        tick_edge();
        run_tick = 1'b1;
        tick_edge();
        run_tick = 1'b0;
        chk("wrap cnt", {16'd0, cycle_count}, 32'h0);
        chk("wrap ce", {31'd0, cpu_enable}, 32'd1);

        // Reset asserted in the middle of a pulse
        tick_edge();
        run_tick = 1'b1;
        tick_edge();
        run_tick = 1'b0;
        chk("midrst pre ce", {31'd0, cpu_enable}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst ce", {31'd0, cpu_enable}, 32'd0);
        chk("midrst cnt", {16'd0, cycle_count}, 32'd0);
        chk("midrst state", {30'd0, state}, 32'd0);
        chk("midrst rr", {31'd0, register_reset}, 32'd1);
        chk("midrst halted", {31'd0, halted}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        tick_edge();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
